// File: rtl/commit_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : commit_regfile_pkg
// Description : Shared sizing constants and the per-register status record
//               (busy flag + producing ROB tag) for the commit register file.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package commit_regfile_pkg;

    localparam int NREG  = 32;   // architectural registers, x0 hardwired zero
    localparam int XLEN  = 32;   // data width
    localparam int ROB_W = 3;    // ROB index width (8 entries)
    localparam int REG_W = 5;    // register address width

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    // Rename-table entry: a busy register awaits the result of ROB entry tag.
    typedef struct packed {
        logic             busy;
        logic [ROB_W-1:0] tag;
    } reg_status_t;

endpackage
`default_nettype wire

// File: rtl/commit_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : commit_regfile_if
// Description : Bundle of the rename, commit, flush and operand-read signals
//               of the commit register file.
// Modports    : master - issue/commit side (drives requests, reads operands)
//               slave  - register file (consumes requests, drives operands)
// Revision    : 1.0 - initial release
// ============================================================================
interface commit_regfile_if;
    import commit_regfile_pkg::*;

    logic             rename_valid;
    logic [REG_W-1:0] rename_rd;
    logic [ROB_W-1:0] rename_rob;

    logic             commit_valid;
    logic [REG_W-1:0] commit_idx;
    logic [XLEN-1:0]  commit_data;
    logic [ROB_W-1:0] commit_rob;

    logic             flush;

    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [XLEN-1:0]  rs1_data;
    logic             rs1_busy;
    logic [ROB_W-1:0] rs1_tag;
    logic [XLEN-1:0]  rs2_data;
    logic             rs2_busy;
    logic [ROB_W-1:0] rs2_tag;

    logic [15:0]      commit_count;

    modport master (
        output rename_valid, rename_rd, rename_rob,
        output commit_valid, commit_idx, commit_data, commit_rob,
        output flush, rs1, rs2,
        input  rs1_data, rs1_busy, rs1_tag,
        input  rs2_data, rs2_busy, rs2_tag,
        input  commit_count
    );

    modport slave (
        input  rename_valid, rename_rd, rename_rob,
        input  commit_valid, commit_idx, commit_data, commit_rob,
        input  flush, rs1, rs2,
        output rs1_data, rs1_busy, rs1_tag,
        output rs2_data, rs2_busy, rs2_tag,
        output commit_count
    );

endinterface
`default_nettype wire

// File: rtl/commit_regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module      : commit_regfile_read_port
// Description : One operand read port. Forces x0 to 0/0/0 and, when the
//               COMMIT_BYPASS_EN macro is defined, forwards a same-cycle
//               commit to the addressed register.
// Ports       : addr          - register address
//               stored_data   - registered value of addr
//               stored_status - registered busy/tag of addr
//               commit_*      - current commit (COMMIT_BYPASS_EN only)
//               data/busy/tag - operand value, busy flag, producing ROB tag
// Revision    : 1.0 - initial release
// ============================================================================
module commit_regfile_read_port
    import commit_regfile_pkg::*;
(
    input  logic [REG_W-1:0] addr,
    input  logic [XLEN-1:0]  stored_data,
    input  reg_status_t      stored_status,
`ifdef COMMIT_BYPASS_EN
    input  logic             commit_valid,
    input  logic [REG_W-1:0] commit_idx,
    input  logic [XLEN-1:0]  commit_data,
    input  logic [ROB_W-1:0] commit_rob,
`endif
    output logic [XLEN-1:0]  data,
    output logic             busy,
    output logic [ROB_W-1:0] tag
);

    logic w_is_zero;
    assign w_is_zero = (addr == ZERO_REG);

`ifdef COMMIT_BYPASS_EN
    logic w_hit;
    assign w_hit = commit_valid && (commit_idx == addr) && !w_is_zero;
`endif

    always_comb begin
        data = stored_data;
        busy = stored_status.busy;
        tag  = stored_status.tag;
`ifdef COMMIT_BYPASS_EN
        if (w_hit) begin
            data = commit_data;
            // The commit only retires the mark if it is still the newest producer.
            if (stored_status.tag == commit_rob) begin
                busy = 1'b0;
            end
        end
`endif
        if (w_is_zero) begin
            data = '0;
            busy = 1'b0;
            tag  = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/commit_regfile.sv
`default_nettype none
// ============================================================================
// Module      : commit_regfile
// Description : Architectural register file with rename-status table fed by
//               the ROB in-order commit port. Rename marks a destination busy
//               on a ROB tag; commit writes the value and clears busy only if
//               the committing entry is still the newest producer; flush
//               clears all busy marks. Two combinational read ports.
//               Optional macro COMMIT_BYPASS_EN: same-cycle commit forwarding
//               onto the read ports.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               bus  - commit_regfile_if.slave (rename/commit/flush/read)
// Revision    : 1.0 - initial release
// ============================================================================
module commit_regfile
    import commit_regfile_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    commit_regfile_if.slave    bus
);

    logic [XLEN-1:0] r_value  [NREG];
    reg_status_t     r_status [NREG];
    logic [15:0]     r_commit_count;

    logic w_commit_wr;
    logic w_rename_wr;
    assign w_commit_wr = bus.commit_valid && (bus.commit_idx != ZERO_REG);
    assign w_rename_wr = bus.rename_valid && (bus.rename_rd != ZERO_REG);

    // Statement order encodes priority: the commit clear is overridden by a
    // same-cycle rename of that register, and flush suppresses any rename.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_value[i]  <= '0;
                r_status[i] <= '0;
            end
            r_commit_count <= '0;
        end else begin
            if (bus.commit_valid) begin
                r_commit_count <= r_commit_count + 16'd1;
            end
            if (w_commit_wr) begin
                r_value[bus.commit_idx] <= bus.commit_data;
                if (r_status[bus.commit_idx].busy &&
                    (r_status[bus.commit_idx].tag == bus.commit_rob)) begin
                    r_status[bus.commit_idx].busy <= 1'b0;
                end
            end
            if (bus.flush) begin
                for (int i = 0; i < NREG; i++) begin
                    r_status[i].busy <= 1'b0;
                end
            end else if (w_rename_wr) begin
                r_status[bus.rename_rd].busy <= 1'b1;
                r_status[bus.rename_rd].tag  <= bus.rename_rob;
            end
        end
    end

    assign bus.commit_count = r_commit_count;

    commit_regfile_read_port u_read_port1 (
        .addr          (bus.rs1),
        .stored_data   (r_value[bus.rs1]),
        .stored_status (r_status[bus.rs1]),
`ifdef COMMIT_BYPASS_EN
        .commit_valid  (bus.commit_valid),
        .commit_idx    (bus.commit_idx),
        .commit_data   (bus.commit_data),
        .commit_rob    (bus.commit_rob),
`endif
        .data          (bus.rs1_data),
        .busy          (bus.rs1_busy),
        .tag           (bus.rs1_tag)
    );

    commit_regfile_read_port u_read_port2 (
        .addr          (bus.rs2),
        .stored_data   (r_value[bus.rs2]),
        .stored_status (r_status[bus.rs2]),
`ifdef COMMIT_BYPASS_EN
        .commit_valid  (bus.commit_valid),
        .commit_idx    (bus.commit_idx),
        .commit_data   (bus.commit_data),
        .commit_rob    (bus.commit_rob),
`endif
        .data          (bus.rs2_data),
        .busy          (bus.rs2_busy),
        .tag           (bus.rs2_tag)
    );

endmodule
`default_nettype wire

// File: tb/tb_commit_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_regfile
// Description : Self-checking bench for commit_regfile: directed scenarios
//               with fixed expected values, then randomized traffic compared
//               every cycle against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_regfile;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    // Reference model state
    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [2:0]  m_tag  [32];
    logic [15:0] m_cnt;

    commit_regfile_if bus ();

    commit_regfile u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef COMMIT_BYPASS_EN
        if (bus.commit_valid && bus.commit_idx == a) return bus.commit_data;
`endif
        return m_val[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
`ifdef COMMIT_BYPASS_EN
        if (bus.commit_valid && bus.commit_idx == a && m_tag[a] == bus.commit_rob) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic logic [2:0] exp_tag(input logic [4:0] a);
        if (a == 5'd0) return 3'd0;
        return m_tag[a];
    endfunction

    task automatic model_clock();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
            m_cnt = '0;
        end else begin
            if (bus.commit_valid) begin
                m_cnt = m_cnt + 16'd1;
                if (bus.commit_idx != 0) begin
                    m_val[bus.commit_idx] = bus.commit_data;
                    if (m_busy[bus.commit_idx] && m_tag[bus.commit_idx] == bus.commit_rob)
                        m_busy[bus.commit_idx] = 1'b0;
                end
            end
            if (bus.flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (bus.rename_valid && bus.rename_rd != 0) begin
                m_busy[bus.rename_rd] = 1'b1;
                m_tag[bus.rename_rd]  = bus.rename_rob;
            end
        end
    endtask

    // One clock: compare read ports against the model mid-cycle, then advance.
    task automatic cyc();
        @(negedge clk);
        check("rs1_data", bus.rs1_data, exp_data(bus.rs1));
        check("rs1_busy", {31'd0, bus.rs1_busy}, {31'd0, exp_busy(bus.rs1)});
        check("rs1_tag",  {29'd0, bus.rs1_tag},  {29'd0, exp_tag(bus.rs1)});
        check("rs2_data", bus.rs2_data, exp_data(bus.rs2));
        check("rs2_busy", {31'd0, bus.rs2_busy}, {31'd0, exp_busy(bus.rs2)});
        check("rs2_tag",  {29'd0, bus.rs2_tag},  {29'd0, exp_tag(bus.rs2)});
        check("commit_count", {16'd0, bus.commit_count}, {16'd0, m_cnt});
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        bus.rename_valid = 1'b0; bus.rename_rd = '0; bus.rename_rob = '0;
        bus.commit_valid = 1'b0; bus.commit_idx = '0; bus.commit_data = '0; bus.commit_rob = '0;
        bus.flush = 1'b0;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [2:0] rob);
        bus.rename_valid = 1'b1; bus.rename_rd = rd; bus.rename_rob = rob;
    endtask

    task automatic commit(input logic [4:0] idx, input logic [2:0] rob, input logic [31:0] d);
        bus.commit_valid = 1'b1; bus.commit_idx = idx; bus.commit_rob = rob; bus.commit_data = d;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) begin
            m_val[i] = 'x; m_busy[i] = 1'bx; m_tag[i] = 'x;
        end
        m_cnt = 'x;
        idle();
        rst = 1'b1;
        bus.rs1 = 5'd5; bus.rs2 = 5'd0;
        @(posedge clk); model_clock(); #1;
        @(posedge clk); model_clock(); #1;
        rst = 1'b0;

        // Reset state
        check("reset_data", bus.rs1_data, 32'd0);
        check("reset_busy", {31'd0, bus.rs1_busy}, 32'd0);
        check("reset_count", {16'd0, bus.commit_count}, 32'd0);

        // Rename then matching commit
        rename(5'd5, 3'd3); cyc(); idle();
        check("ren_busy", {31'd0, bus.rs1_busy}, 32'd1);
        check("ren_tag", {29'd0, bus.rs1_tag}, 32'd3);
        commit(5'd5, 3'd3, 32'hDEADBEEF); cyc(); idle();
        check("cmt_data", bus.rs1_data, 32'hDEADBEEF);
        check("cmt_busy", {31'd0, bus.rs1_busy}, 32'd0);
        check("cmt_count", {16'd0, bus.commit_count}, 32'd1);

        // Stale commit must not clear the newer producer
        bus.rs1 = 5'd7;
        rename(5'd7, 3'd1); cyc();
        rename(5'd7, 3'd4); cyc(); idle();
        commit(5'd7, 3'd1, 32'h11); cyc(); idle();
        check("stale_data", bus.rs1_data, 32'h11);
        check("stale_busy", {31'd0, bus.rs1_busy}, 32'd1);
        check("stale_tag", {29'd0, bus.rs1_tag}, 32'd4);

        // Same-cycle commit and rename on one register: rename wins
        bus.rs1 = 5'd9;
        rename(5'd9, 3'd2); cyc(); idle();
        commit(5'd9, 3'd2, 32'h99); rename(5'd9, 3'd6); cyc(); idle();
        check("same_data", bus.rs1_data, 32'h99);
        check("same_busy", {31'd0, bus.rs1_busy}, 32'd1);
        check("same_tag", {29'd0, bus.rs1_tag}, 32'd6);

        // Flush clears busy and drops the concurrent rename
        bus.rs1 = 5'd3; bus.rs2 = 5'd4;
        rename(5'd3, 3'd1); cyc();
        rename(5'd4, 3'd2); cyc(); idle();
        bus.flush = 1'b1; rename(5'd8, 3'd7); cyc(); idle();
        check("flush_x3", {31'd0, bus.rs1_busy}, 32'd0);
        check("flush_x4", {31'd0, bus.rs2_busy}, 32'd0);
        bus.rs1 = 5'd8; #1;
        check("flush_x8", {31'd0, bus.rs1_busy}, 32'd0);

        // x0 ignores rename/commit, but the commit is still counted
        bus.rs1 = 5'd0;
        rename(5'd0, 3'd5); commit(5'd0, 3'd0, 32'hFF); cyc(); idle();
        check("x0_data", bus.rs1_data, 32'd0);
        check("x0_busy", {31'd0, bus.rs1_busy}, 32'd0);
        check("x0_tag", {29'd0, bus.rs1_tag}, 32'd0);
        check("x0_count", {16'd0, bus.commit_count}, 32'd4);

        // Same-cycle visibility of a commit
        bus.rs2 = 5'd12;
        rename(5'd12, 3'd0); cyc(); idle();
        commit(5'd12, 3'd0, 32'hA5A5); #1;
`ifdef COMMIT_BYPASS_EN
        check("byp_data", bus.rs2_data, 32'hA5A5);
        check("byp_busy", {31'd0, bus.rs2_busy}, 32'd0);
`else
        check("byp_data", bus.rs2_data, 32'd0);
        check("byp_busy", {31'd0, bus.rs2_busy}, 32'd1);
`endif
        cyc(); idle(); #1;
        check("byp_next_data", bus.rs2_data, 32'hA5A5);
        check("byp_next_busy", {31'd0, bus.rs2_busy}, 32'd0);

        // Randomized traffic; small register range to provoke collisions
        for (int n = 0; n < 600; n++) begin
            rst              = ($urandom_range(0, 99) == 0);
            bus.rename_valid = $urandom_range(0, 1) == 1;
            bus.rename_rd    = 5'($urandom_range(0, 11));
            bus.rename_rob   = 3'($urandom);
            bus.commit_valid = $urandom_range(0, 2) != 0;
            bus.commit_idx   = 5'($urandom_range(0, 11));
            bus.commit_data  = $urandom;
            // Bias commit tag toward the stored one so clears actually happen
            bus.commit_rob   = ($urandom_range(0, 1) == 1) ? m_tag[bus.commit_idx] : 3'($urandom);
            bus.flush        = ($urandom_range(0, 15) == 0);
            bus.rs1          = ($urandom_range(0, 3) == 0) ? bus.commit_idx : 5'($urandom_range(0, 11));
            bus.rs2          = 5'($urandom);
            cyc();
        end
        idle();
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
